// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants and state encoding for the truth-table sequencer.
package truth_table_sequencer_pkg;

    localparam int unsigned VEC_W       = 4;
    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned ONES_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic is_last_vector(input logic [VEC_W-1:0] v);
        return v == VEC_W'(NUM_VECTORS - 1);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_counter.sv
// Loadable 4-bit down-counter timing how long each vector is held.
module truth_table_sequencer_settle_counter
    import truth_table_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 input vectors of a 4-input function, holding each for SETTLE
// cycles and capturing the response into a truth table plus a ones count.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    output logic [VEC_W-1:0]       x,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] table_out,
    output logic [ONES_W-1:0]      ones_count
);

    state_e                 state_q, state_d;
    logic [VEC_W-1:0]       x_q, x_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_VECTORS-1:0] table_q, table_d;
    logic [ONES_W-1:0]      ones_q, ones_d;

    logic                   cnt_load;
    logic                   cnt_dec;
    logic [CNT_W-1:0]       cnt;

    truth_table_sequencer_settle_counter u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(SETTLE)),
        .count    (cnt)
    );

    // Next-state and datapath; abort pre-empts both settling and capture.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        table_d  = table_q;
        ones_d   = ones_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    x_d      = '0;
                    table_d  = '0;
                    ones_d   = '0;
                    cnt_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    table_d[x_q] = f_in;
                    ones_d       = ones_q + ONES_W'(f_in);
                    if (is_last_vector(x_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d      = x_q + VEC_W'(1);
                        cnt_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            ones_q  <= ones_d;
        end
    end

    assign x          = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_out  = table_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: table-driven sweeps on SETTLE=1 and
// SETTLE=3 instances plus hand-written start-held, abort and reset sequences.
module tb_truth_table_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start1, start3;
    logic        abort1, abort3;
    logic        f1, f3;
    logic [3:0]  x1, x3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  ones1, ones3;

    int          mode;
    int          sel;
    int          n_checks;
    int          n_pass;

    logic [3:0]  obs_x;
    logic        obs_busy;
    logic        obs_done;
    logic [15:0] obs_tbl;
    logic [4:0]  obs_ones;

    truth_table_sequencer #(.SETTLE(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .abort      (abort1),
        .f_in       (f1),
        .x          (x1),
        .busy       (busy1),
        .done       (done1),
        .table_out  (tbl1),
        .ones_count (ones1)
    );

    truth_table_sequencer #(.SETTLE(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .abort      (abort3),
        .f_in       (f3),
        .x          (x3),
        .busy       (busy3),
        .done       (done3),
        .table_out  (tbl3),
        .ones_count (ones3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function under test, selected by mode.
    function automatic logic fmodel(input int m, input logic [3:0] v);
        case (m)
            0:       return (v[3] & v[2]) | v[1];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[0];
            4:       return v == 4'hA;
            default: return 1'b0;
        endcase
    endfunction

    always_comb f1 = fmodel(mode, x1);
    always_comb f3 = fmodel(mode, x3);

    always_comb begin
        if (sel == 0) begin
            obs_x = x1; obs_busy = busy1; obs_done = done1; obs_tbl = tbl1; obs_ones = ones1;
        end else begin
            obs_x = x3; obs_busy = busy3; obs_done = done3; obs_tbl = tbl3; obs_ones = ones3;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the selected instance and follow the sweep until done.
    task automatic run_sweep(input int sel_i, input int mode_i, output int cyc, output int seq_err);
        int settle;
        int run;
        logic [3:0] prev_x;
        sel     = sel_i;
        mode    = mode_i;
        settle  = (sel_i == 0) ? 1 : 3;
        seq_err = 0;
        if (sel_i == 0) start1 = 1'b1; else start3 = 1'b1;
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
        cyc    = 0;
        prev_x = obs_x;
        run    = 1;
        if (obs_x != 4'd0 || !obs_busy) seq_err++;
        while (!obs_done && cyc < 200) begin
            tick();
            cyc++;
            if (!obs_done) begin
                if (!obs_busy) seq_err++;
                if (obs_x == prev_x) run++;
                else begin
                    if (obs_x != prev_x + 4'd1 || run != settle + 1) seq_err++;
                    prev_x = obs_x;
                    run    = 1;
                end
            end
        end
        if (obs_x != 4'hF || run != settle + 1) seq_err++;
    endtask

    typedef struct {
        int          sel;
        int          mode;
        logic [15:0] tbl;
        logic [4:0]  ones;
        int          cycles;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        int err;
        int bad;

        vecs[0] = '{0, 0, 16'hFCCC, 5'd10, 32};
        vecs[1] = '{1, 1, 16'h0000, 5'd0,  64};
        vecs[2] = '{1, 2, 16'hFFFF, 5'd16, 64};
        vecs[3] = '{0, 2, 16'hFFFF, 5'd16, 32};
        vecs[4] = '{0, 1, 16'h0000, 5'd0,  32};
        vecs[5] = '{0, 3, 16'hAAAA, 5'd8,  32};
        vecs[6] = '{1, 4, 16'h0400, 5'd1,  64};

        n_checks = 0;
        n_pass   = 0;
        mode     = 0;
        sel      = 0;
        rst_n    = 1'b0;
        start1   = 1'b0;
        start3   = 1'b0;
        abort1   = 1'b0;
        abort3   = 1'b0;
        repeat (3) tick();

        check("rst_x",    32'(x1),    32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_done", 32'(done1), 32'h0);
        check("rst_tbl",  32'(tbl1),  32'h0);
        check("rst_ones", 32'(ones1), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            run_sweep(vecs[i].sel, vecs[i].mode, cyc, err);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("v%0d_table", i),  32'(obs_tbl), 32'(vecs[i].tbl));
            check($sformatf("v%0d_ones", i),   32'(obs_ones), 32'(vecs[i].ones));
            check($sformatf("v%0d_seq", i),    32'(err), 32'h0);
            tick();
            check($sformatf("v%0d_done_end", i), 32'(obs_done), 32'h0);
            check($sformatf("v%0d_idle_busy", i), 32'(obs_busy), 32'h0);
            check($sformatf("v%0d_x_hold", i), 32'(obs_x), 32'hF);
            repeat (2) tick();
        end

        // start held high across a full sweep and into a second one
        sel = 0; mode = 0;
        start1 = 1'b1;
        tick();
        cyc = 0;
        while (!done1 && cyc < 200) begin tick(); cyc++; end
        check("hold_cycles1", 32'(cyc), 32'd32);
        tick();
        check("hold_idle_done", 32'(done1), 32'h0);
        check("hold_idle_busy", 32'(busy1), 32'h0);
        tick();
        check("hold_restart_busy", 32'(busy1), 32'h1);
        check("hold_restart_x",    32'(x1),    32'h0);
        check("hold_restart_tbl",  32'(tbl1),  32'h0);
        check("hold_restart_ones", 32'(ones1), 32'h0);
        cyc = 0;
        while (!done1 && cyc < 200) begin tick(); cyc++; end
        check("hold_cycles2", 32'(cyc), 32'd32);
        check("hold_table2",  32'(tbl1), 32'hFCCC);
        start1 = 1'b0;
        tick();
        check("hold_single_pulse", 32'(done1), 32'h0);
        tick();
        check("hold_final_idle", 32'(busy1), 32'h0);

        // abort during capture of x=5 with f_in=1
        mode = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("abort_at_x", 32'(x1), 32'h5);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_busy",  32'(busy1), 32'h0);
        check("abort_done",  32'(done1), 32'h0);
        check("abort_table", 32'(tbl1),  32'h001F);
        check("abort_ones",  32'(ones1), 32'h5);
        check("abort_x",     32'(x1),    32'h5);
        // abort while idle must leave the partial result alone
        abort1 = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done1 || busy1 || tbl1 != 16'h001F) bad++;
        end
        abort1 = 1'b0;
        check("abort_quiet", 32'(bad), 32'h0);

        // synchronous reset mid-sweep at x=9
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("rst9_at_x", 32'(x1), 32'h9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst9_x",    32'(x1),    32'h0);
        check("rst9_busy", 32'(busy1), 32'h0);
        check("rst9_done", 32'(done1), 32'h0);
        check("rst9_tbl",  32'(tbl1),  32'h0);
        check("rst9_ones", 32'(ones1), 32'h0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done1 || busy1) bad++;
        end
        check("rst9_quiet", 32'(bad), 32'h0);
        run_sweep(0, 0, cyc, err);
        check("rst9_resweep_cycles", 32'(cyc), 32'd32);
        check("rst9_resweep_table",  32'(tbl1), 32'hFCCC);
        check("rst9_resweep_ones",   32'(ones1), 32'd10);
        check("rst9_resweep_seq",    32'(err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each input vector is held before f is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin an exhaustive 16-vector sweep; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-006 SHALL have port f_in  input  1  response of the 4-input function under test.
REQ-007 SHALL have port x  output  4  stimulus vector; x[3]=x1 (MSB) .. x[0]=x4 (LSB).
REQ-008 SHALL have port busy  output  1  high in SETTLE and CAPTURE.
REQ-009 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-010 SHALL have port table_out  output  16  captured truth table; bit i = f_in observed with x==i.
REQ-011 SHALL have port ones_count  output  5  number of vectors for which f_in was 1 (0..16).

Function
REQ-012 SHALL implement states IDLE, SETTLE, CAPTURE, DONE; all outputs registered.
REQ-013 IDLE: on start=1, next cycle x=0, table_out=0, ones_count=0, 4-bit settle counter loaded with SETTLE, state SETTLE.
REQ-014 SETTLE: counter decrements each cycle; state stays exactly SETTLE cycles, then CAPTURE.
REQ-015 CAPTURE (one cycle): table_out[x] <= f_in; ones_count += f_in.
REQ-016 CAPTURE with x==15: next state DONE, x holds 15; otherwise x <= x+1, counter reloaded, next state SETTLE.
REQ-017 Per vector cost SETTLE+1 cycles; done SHALL rise exactly 16*(SETTLE+1) cycles after the edge that accepted start.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; start during DONE ignored.
REQ-019 start while busy SHALL be ignored; no restart, no clearing.
REQ-020 abort=1 in SETTLE or CAPTURE: next state IDLE, done not pulsed, table_out/ones_count keep partial values, capture in that cycle suppressed; abort has priority over capture.
REQ-021 abort in IDLE or DONE SHALL have no effect (DONE still pulses done).
REQ-022 table_out, ones_count, x SHALL hold last values in IDLE until next accepted start.
REQ-023 ones_count SHALL not wrap: max 16 reached only with all 16 captures = 1.

Reset
REQ-024 rst_n=0 at a clock edge: state IDLE, x=0, busy=0, done=0, table_out=0, ones_count=0, counter=0.
REQ-025 Reset mid-sweep SHALL abandon the sweep with no done pulse; first start after release begins at x=0.
REQ-026 Reset SHALL take priority over start and abort.

Structure
REQ-027 State encodings (2-bit), NUM_VECTORS=16 and vector width 4 SHALL reside in a shared package/include file.
REQ-028 Sub-module: none required; optional settle_counter (4-bit loadable down-counter) SHALL be the only one if split out.

Verification
REQ-029 f_in = x1&x2 | x3 modelled combinationally, SETTLE=1, pulse start -> done at cycle 32, table_out=16'hFCCC, ones_count=10.
REQ-030 f_in tied 0 then 1, SETTLE=3 -> done at cycle 64; table_out=16'h0000/ones_count=0, then 16'hFFFF/ones_count=16.
REQ-031 start held high through whole sweep -> exactly one done pulse, one-cycle IDLE after DONE, then second sweep starts from x=0.
REQ-032 abort asserted in CAPTURE of x=5, f_in=1 -> IDLE next cycle, no done, table_out=16'h001F, ones_count=5.
REQ-033 rst_n=0 for one cycle at x=9 -> all outputs 0 next cycle; fresh start completes normally with correct table.
REQ-034 Every run: x increments by exactly 1 and stays stable SETTLE+1 cycles; busy high from cycle after start until DONE.
